cgra_io_probe: RTL and testbench

// - Parametrised timing/observation harness for the CGRA accelerator top. It starts one accelerator
//   run, compresses NUM_CH load-data streams into per-channel MISR signatures and counts run cycles.
// - Results come out through one narrow, registered, selectable probe port, so synthesis keeps all

---
 rtl/cgra_io_probe_if.sv | 28 ++
 rtl/cgra_io_probe.sv | 124 ++++++++++++
 tb/tb_cgra_io_probe.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cgra_io_probe_if.sv
// Pin-side bundle of the CGRA I/O probe: run handshake, load-data capture and probe readout.
// master drives the stimulus side (pins/bench); slave is the probe itself.
interface cgra_io_probe_if #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned OWIDTH    = 8,
  parameter int unsigned SEL_WIDTH = 2
);
  logic                     run_start;
  logic                     accel_start;
  logic                     accel_done;
  logic                     load_en;
  logic [NUM_CH*DWIDTH-1:0] data_load;
  logic [SEL_WIDTH-1:0]     probe_sel;
  logic [OWIDTH-1:0]        probe_out;
  logic                     probe_busy;
  logic                     probe_done;

  modport master (
    output run_start, accel_done, load_en, data_load, probe_sel,
    input  accel_start, probe_out, probe_busy, probe_done
  );

  modport slave (
    input  run_start, accel_done, load_en, data_load, probe_sel,
    output accel_start, probe_out, probe_busy, probe_done
  );
endinterface

// File: rtl/cgra_io_probe.sv
// Run-control and observation harness: one accelerator run, per-channel MISR signatures, run-cycle
// counter, all read back through a narrow registered probe. Counter built only with
// CGRA_PROBE_CYCLE_COUNT_EN defined.
module cgra_io_probe #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned OWIDTH    = 8,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned SEL_WIDTH = 2,
  parameter logic [31:0] POLY      = 32'h04C11DB7
) (
  input logic             clk,
  input logic             rst_n,
  cgra_io_probe_if.slave  bus
);

  localparam logic [DWIDTH-1:0] Poly = DWIDTH'(POLY);

  if ((DWIDTH % OWIDTH) != 0 || CNT_WIDTH == 0 || (2 ** SEL_WIDTH) < (NUM_CH + 1)) begin : g_bad_cfg
    $error("cgra_io_probe: unsupported parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [DWIDTH-1:0] sig_q [NUM_CH];
  logic [DWIDTH-1:0] sig_d [NUM_CH];
  logic [OWIDTH-1:0] probe_q, probe_d;

  function automatic logic [DWIDTH-1:0] misr_step(input logic [DWIDTH-1:0] sig,
                                                  input logic [DWIDTH-1:0] data);
    return ({sig[DWIDTH-2:0], 1'b0} ^ (sig[DWIDTH-1] ? Poly : '0)) ^ data;
  endfunction

  function automatic logic [OWIDTH-1:0] fold_data(input logic [DWIDTH-1:0] v);
    logic [OWIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(DWIDTH / OWIDTH); i++) acc ^= v[i*OWIDTH +: OWIDTH];
    return acc;
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.run_start) state_d = StStart;
      StStart: state_d = StRun;
      StRun:   if (bus.accel_done) state_d = StDone;
      StDone:  if (bus.run_start) state_d = StStart;
      default: state_d = StIdle;
    endcase
  end

  assign bus.accel_start = (state_q == StStart);
  assign bus.probe_busy  = (state_q == StStart) || (state_q == StRun);
  assign bus.probe_done  = (state_q == StDone);
  assign bus.probe_out   = probe_q;

  // A word arriving with Accel_Done is still folded in before DONE.
  always_comb begin
    for (int k = 0; k < int'(NUM_CH); k++) begin
      sig_d[k] = sig_q[k];
      if (state_q == StStart) begin
        sig_d[k] = '0;
      end else if (state_q == StRun && bus.load_en) begin
        sig_d[k] = misr_step(sig_q[k], bus.data_load[k*DWIDTH +: DWIDTH]);
      end
    end
  end

`ifdef CGRA_PROBE_CYCLE_COUNT_EN
  localparam int unsigned CntPad = ((CNT_WIDTH + OWIDTH - 1) / OWIDTH) * OWIDTH;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CntPad-1:0]    cnt_ext;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StStart) begin
      cnt_d = '0;
    end else if (state_q == StRun && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_ext = CntPad'(cnt_q);

  function automatic logic [OWIDTH-1:0] fold_cnt(input logic [CntPad-1:0] v);
    logic [OWIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(CntPad / OWIDTH); i++) acc ^= v[i*OWIDTH +: OWIDTH];
    return acc;
  endfunction
`endif

  // Unmapped selects (including the counter slot when it is not built) read as zero.
  always_comb begin
    probe_d = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (bus.probe_sel == SEL_WIDTH'(k)) probe_d = fold_data(sig_q[k]);
    end
`ifdef CGRA_PROBE_CYCLE_COUNT_EN
    if (bus.probe_sel == SEL_WIDTH'(NUM_CH)) probe_d = fold_cnt(cnt_ext);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      probe_q <= '0;
      for (int k = 0; k < int'(NUM_CH); k++) sig_q[k] <= '0;
    end else begin
      state_q <= state_d;
      probe_q <= probe_d;
      for (int k = 0; k < int'(NUM_CH); k++) sig_q[k] <= sig_d[k];
    end
  end

endmodule

// File: tb/tb_cgra_io_probe.sv
// Directed self-checking bench for cgra_io_probe; expectations follow CGRA_PROBE_CYCLE_COUNT_EN.
module tb_cgra_io_probe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   starts;

`ifdef CGRA_PROBE_CYCLE_COUNT_EN
  localparam logic [7:0] ExpCnt10 = 8'h0A;
  localparam logic [7:0] ExpSat   = 8'h0F;
`else
  localparam logic [7:0] ExpCnt10 = 8'h00;
  localparam logic [7:0] ExpSat   = 8'h00;
`endif

  cgra_io_probe_if #(.NUM_CH(2), .DWIDTH(32), .OWIDTH(8), .SEL_WIDTH(2)) a ();
  cgra_io_probe_if #(.NUM_CH(2), .DWIDTH(32), .OWIDTH(8), .SEL_WIDTH(2)) b ();

  cgra_io_probe #(.NUM_CH(2), .DWIDTH(32), .OWIDTH(8), .CNT_WIDTH(16), .SEL_WIDTH(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  cgra_io_probe #(.NUM_CH(2), .DWIDTH(32), .OWIDTH(8), .CNT_WIDTH(4), .SEL_WIDTH(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    starts = 0;
    rst_n = 1'b0;
    a.run_start = 1'b0; a.accel_done = 1'b0; a.load_en = 1'b0; a.data_load = '0; a.probe_sel = 2'd0;
    b.run_start = 1'b0; b.accel_done = 1'b0; b.load_en = 1'b0; b.data_load = '0; b.probe_sel = 2'd2;
    step();
    step();
    chk("rst_probe", 32'(a.probe_out), 32'h0);
    chk("rst_start", 32'(a.accel_start), 32'h0);
    chk("rst_busy", 32'(a.probe_busy), 32'h0);
    chk("rst_done", 32'(a.probe_done), 32'h0);
    rst_n = 1'b1;
    step();
    chk("exit_no_start", 32'(a.accel_start), 32'h0);

    // Run 1: Run_Start held five cycles, Accel_Done on the 10th RUN cycle.
    a.run_start = 1'b1;
    b.run_start = 1'b1;
    step();
    starts += int'(a.accel_start);
    chk("start_pulse", 32'(a.accel_start), 32'h1);
    chk("start_busy", 32'(a.probe_busy), 32'h1);
    b.run_start = 1'b0;
    step();
    starts += int'(a.accel_start);
    a.load_en = 1'b1;
    a.data_load = {32'hDEADBEEF, 32'h00000001};
    step();
    starts += int'(a.accel_start);
    a.data_load = {32'h12345678, 32'h00000000};
    step();
    starts += int'(a.accel_start);
    chk("sig0_word1", 32'(a.probe_out), 32'h01);
    a.load_en = 1'b0;
    step();
    starts += int'(a.accel_start);
    chk("sig0_word2", 32'(a.probe_out), 32'h02);
    a.run_start = 1'b0;
    chk("single_pulse", 32'(starts), 32'd1);
    chk("busy_in_run", 32'(a.probe_busy), 32'h1);
    repeat (6) step();
    a.accel_done = 1'b1;
    a.load_en = 1'b1;
    a.data_load = {32'h00000001, 32'h00000100};
    step();
    a.accel_done = 1'b0;
    a.load_en = 1'b0;
    chk("done_flag", 32'(a.probe_done), 32'h1);
    chk("done_not_busy", 32'(a.probe_busy), 32'h0);
    step();
    chk("sig0_last_word", 32'(a.probe_out), 32'h05);
    a.probe_sel = 2'd1;
    step();
    chk("sig1_final", 32'(a.probe_out), 32'h2B);
    a.probe_sel = 2'd2;
    step();
    chk("count_10", 32'(a.probe_out), 32'(ExpCnt10));
    a.probe_sel = 2'd3;
    step();
    chk("sel_out_of_range", 32'(a.probe_out), 32'h0);
    a.probe_sel = 2'd0;
    a.load_en = 1'b1;
    a.data_load = {32'hCAFEF00D, 32'h5A5A5A5A};
    step();
    step();
    a.load_en = 1'b0;
    chk("done_hold", 32'(a.probe_out), 32'h05);

    // Narrow-counter instance has been running since the start of run 1.
    repeat (8) step();
    b.accel_done = 1'b1;
    step();
    b.accel_done = 1'b0;
    chk("sat_done", 32'(b.probe_done), 32'h1);
    step();
    chk("sat_count", 32'(b.probe_out), 32'(ExpSat));

    // Restart from DONE; exercise the MISR feedback tap.
    a.run_start = 1'b1;
    step();
    chk("restart_pulse", 32'(a.accel_start), 32'h1);
    chk("restart_not_done", 32'(a.probe_done), 32'h0);
    a.run_start = 1'b0;
    step();
    step();
    chk("restart_clear", 32'(a.probe_out), 32'h0);
    a.load_en = 1'b1;
    a.data_load = {32'h00000000, 32'h80000000};
    step();
    a.data_load = '0;
    step();
    a.load_en = 1'b0;
    step();
    chk("misr_poly", 32'(a.probe_out), 32'h6F);
    a.run_start = 1'b1;
    step();
    chk("run_start_ignored", 32'(a.accel_start), 32'h0);
    chk("still_busy", 32'(a.probe_busy), 32'h1);
    a.run_start = 1'b0;

    // Asynchronous abort in the middle of RUN.
    rst_n = 1'b0;
    #1;
    chk("abort_probe", 32'(a.probe_out), 32'h0);
    chk("abort_busy", 32'(a.probe_busy), 32'h0);
    chk("abort_start", 32'(a.accel_start), 32'h0);
    chk("abort_done", 32'(a.probe_done), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("abort_exit_start", 32'(a.accel_start), 32'h0);
    chk("abort_exit_busy", 32'(a.probe_busy), 32'h0);
    step();
    chk("abort_sig_clear", 32'(a.probe_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
